// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding and key-field helpers for the keypad emulator
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      HOLD       = 3'd1,
      GAP        = 3'd2
`ifdef KEYPAD_EMU_BOUNCE_EN
      ,
      BOUNCE_IN  = 3'd3,
      BOUNCE_OUT = 3'd4
`endif
   } state_t;

   localparam int KEY_FIELD_W = 2;
   localparam int KEY_ROW_LSB = 2;
   localparam int KEY_COL_LSB = 0;

   function automatic logic [KEY_FIELD_W-1:0] key_row(input logic [3:0] key);
      return key[KEY_ROW_LSB +: KEY_FIELD_W];
   endfunction

   function automatic logic [KEY_FIELD_W-1:0] key_col(input logic [3:0] key);
      return key[KEY_COL_LSB +: KEY_FIELD_W];
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/keypad_emu_cnt.sv
// rtl/keypad_emu_cnt.sv - loadable down-counter that times every emulator phase
module keypad_emu_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   // Saturates at zero; every phase that needs it reloads on entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_value;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/keypad_emu.sv
// rtl/keypad_emu.sv - matrix keypad contact emulator; contact bounce enabled by KEYPAD_EMU_BOUNCE_EN
module keypad_emu
   import keypad_pkg::*;
#(
   parameter int HOLD_W        = 16,
   parameter int GAP_CYCLES    = 8,
   parameter int BOUNCE_CYCLES = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_key,
   input  logic [HOLD_W-1:0] cmd_hold,
   input  logic [3:0]        col,
   output logic [3:0]        row,
   output logic              pressed,
   output logic              done
);

   localparam int CNT_W = max_int(HOLD_W, max_int($clog2(GAP_CYCLES + 1), $clog2(BOUNCE_CYCLES + 1)));
   localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

   state_t           r_state;
   logic             r_ready;
   logic             r_done;
   logic             r_pressed;
   logic [3:0]       r_key;
   logic [3:0]       r_row;
   logic [3:0]       w_row_nxt;
   logic             w_contact;
   logic             w_load;
   logic             w_zero;
   logic [CNT_W-1:0] w_load_val;
   logic [CNT_W-1:0] w_hold_m1;

   // A zero hold still closes the contact for one cycle.
   assign w_hold_m1 = (cmd_hold == '0) ? '0 : CNT_W'(cmd_hold) - CNT_W'(1);

`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES - 1);
   logic             r_phase;
   logic [CNT_W-1:0] r_hold_m1;

   assign w_contact = (r_state == HOLD) ||
                      (((r_state == BOUNCE_IN) || (r_state == BOUNCE_OUT)) && !r_phase);
`else
   assign w_contact = (r_state == HOLD);
`endif

   always_comb begin
      w_load     = 1'b0;
      w_load_val = '0;
      case (r_state)
         IDLE: begin
            if (cmd_valid && r_ready) begin
               w_load = 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
               w_load_val = BOUNCE_LOAD;
`else
               w_load_val = w_hold_m1;
`endif
            end
         end
`ifdef KEYPAD_EMU_BOUNCE_EN
         BOUNCE_IN: begin
            w_load     = w_zero;
            w_load_val = r_hold_m1;
         end
         HOLD: begin
            w_load     = w_zero;
            w_load_val = BOUNCE_LOAD;
         end
         BOUNCE_OUT: begin
            w_load     = w_zero;
            w_load_val = GAP_LOAD;
         end
`else
         HOLD: begin
            w_load     = w_zero;
            w_load_val = GAP_LOAD;
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      w_row_nxt = 4'b1111;
      if (w_contact && !col[key_col(r_key)]) begin
         w_row_nxt[key_row(r_key)] = 1'b0;
      end
   end

   keypad_emu_cnt #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_zero  (w_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_ready   <= 1'b1;
         r_done    <= 1'b0;
         r_key     <= '0;
         r_row     <= 4'b1111;
         r_pressed <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
         r_phase   <= 1'b0;
         r_hold_m1 <= '0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_row     <= w_row_nxt;
         r_pressed <= w_contact;
`ifdef KEYPAD_EMU_BOUNCE_EN
         r_phase   <= ~r_phase;
`endif
         case (r_state)
            IDLE: begin
               if (cmd_valid && r_ready) begin
                  r_key   <= cmd_key;
                  r_ready <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                  r_hold_m1 <= w_hold_m1;
                  r_phase   <= 1'b0;
                  r_state   <= BOUNCE_IN;
`else
                  r_state <= HOLD;
`endif
               end
            end
`ifdef KEYPAD_EMU_BOUNCE_EN
            BOUNCE_IN:  if (w_zero) r_state <= HOLD;
            HOLD: begin
               if (w_zero) begin
                  r_state <= BOUNCE_OUT;
                  r_phase <= 1'b0;
               end
            end
            BOUNCE_OUT: if (w_zero) r_state <= GAP;
`else
            HOLD:       if (w_zero) r_state <= GAP;
`endif
            GAP: begin
               if (w_zero) begin
                  r_state <= IDLE;
                  r_ready <= 1'b1;
                  r_done  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready = r_ready;
   assign row       = r_row;
   assign pressed   = r_pressed;
   assign done      = r_done;

endmodule

// File: tb/tb_keypad_emu.sv
// tb/tb_keypad_emu.sv - self-checking bench for keypad_emu against a timeline reference model
module tb_keypad_emu;

   localparam int HOLD_W        = 16;
   localparam int GAP_CYCLES    = 8;
   localparam int BOUNCE_CYCLES = 6;
`ifdef KEYPAD_EMU_BOUNCE_EN
   localparam bit BOUNCE = 1'b1;
`else
   localparam bit BOUNCE = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [3:0]        cmd_key = 4'd0;
   logic [HOLD_W-1:0] cmd_hold = '0;
   logic [3:0]        col = 4'b1111;
   logic [3:0]        row;
   logic              pressed;
   logic              done;

   int n_vec = 0;
   int n_err = 0;

   bit         m_q[$];
   bit         m_busy, m_cont, m_done, m_ready, e_pressed;
   logic [3:0] m_key, e_row;

   always #5 clk = ~clk;

   keypad_emu #(
      .HOLD_W        (HOLD_W),
      .GAP_CYCLES    (GAP_CYCLES),
      .BOUNCE_CYCLES (BOUNCE_CYCLES)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_key   (cmd_key),
      .cmd_hold  (cmd_hold),
      .col       (col),
      .row       (row),
      .pressed   (pressed),
      .done      (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_busy = 1'b0; m_cont = 1'b0; m_done = 1'b0; m_ready = 1'b1;
      m_key = 4'd0; e_pressed = 1'b0; e_row = 4'b1111;
   endtask

   // Contact timeline of one command, one entry per cycle after acceptance.
   task automatic build(input logic [3:0] key, input logic [HOLD_W-1:0] hold);
      int n;
      m_key = key;
      m_q.delete();
      n = (hold == '0) ? 1 : int'(hold);
      if (BOUNCE) for (int i = 0; i < BOUNCE_CYCLES; i++) m_q.push_back(i % 2 == 0);
      for (int i = 0; i < n; i++) m_q.push_back(1'b1);
      if (BOUNCE) for (int i = 0; i < BOUNCE_CYCLES; i++) m_q.push_back(i % 2 == 0);
      for (int i = 0; i < GAP_CYCLES; i++) m_q.push_back(1'b0);
   endtask

   task automatic model_edge();
      e_pressed = m_cont;
      e_row = 4'b1111;
      if (m_cont && !col[m_key % 4]) e_row[m_key / 4] = 1'b0;
      m_done = 1'b0;
      if (!m_busy) begin
         if (cmd_valid) begin
            build(cmd_key, cmd_hold);
            m_busy = 1'b1;
            m_cont = m_q.pop_front();
         end else begin
            m_cont = 1'b0;
         end
      end else if (m_q.size() > 0) begin
         m_cont = m_q.pop_front();
      end else begin
         m_busy = 1'b0;
         m_done = 1'b1;
         m_cont = 1'b0;
      end
      m_ready = !m_busy;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("pressed", 32'(pressed), 32'(e_pressed));
      chk("row", 32'(row), 32'(e_row));
      chk("done", 32'(done), 32'(m_done));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
   endtask

   task automatic issue(input logic [3:0] key, input logic [HOLD_W-1:0] hold);
      cmd_valid = 1'b1; cmd_key = key; cmd_hold = hold;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Runs to the done pulse; counts pressed cycles and pressed cycles showing match_row.
   task automatic watch(input logic [3:0] match_row, output int n_press, output int n_match, output int gap);
      int last = -1;
      bit seen = 1'b0;
      n_press = 0; n_match = 0; gap = -1;
      for (int t = 0; t < 200 && !seen; t++) begin
         tick();
         if (pressed === 1'b1) begin
            n_press++;
            last = t;
            if (row === match_row) n_match++;
         end
         if (done === 1'b1) begin
            seen = 1'b1;
            gap = t - last;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   function automatic int closed_cycles(input int hold);
      return ((hold == 0) ? 1 : hold) + (BOUNCE ? 2 * ((BOUNCE_CYCLES + 1) / 2) : 0);
   endfunction

   initial begin
      int np, nm, gp;
      bit exp_seq[16];
      model_reset();

      repeat (2) @(negedge clk);
      chk("rst_row", 32'(row), 32'hF);
      chk("rst_pressed", 32'(pressed), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b1;
      chk("ready_after_reset", 32'(cmd_ready), 32'd1);
      tick();

      // key 6 = row 1, column 2
      col = 4'b1011;
      issue(4'd6, 16'd4);
      watch(4'b1101, np, nm, gp);
      chk("k6_closed", 32'(np), 32'(closed_cycles(4)));
      chk("k6_row_low", 32'(nm), 32'(np));
`ifndef KEYPAD_EMU_BOUNCE_EN
      chk("k6_row_low_4", 32'(nm), 32'd4);
      chk("k6_done_gap", 32'(gp), 32'(GAP_CYCLES));
`endif

      col = 4'b0111;
      issue(4'd6, 16'd5);
      watch(4'b1111, np, nm, gp);
      chk("wrong_col_closed", 32'(np), 32'(closed_cycles(5)));
      chk("wrong_col_row_high", 32'(nm), 32'(np));

      col = 4'b0000;
      issue(4'd15, 16'd3);
      watch(4'b0111, np, nm, gp);
      chk("all_cols_closed", 32'(np), 32'(closed_cycles(3)));
      chk("all_cols_row", 32'(nm), 32'(np));

      col = 4'b1101;
      issue(4'd9, 16'd0);
      watch(4'b1011, np, nm, gp);
      chk("hold0_closed", 32'(np), 32'(closed_cycles(0)));
      chk("hold0_row", 32'(nm), 32'(np));
      cmd_valid = 1'b1; cmd_key = 4'd3; cmd_hold = 16'd2;
      chk("b2b_ready_on_done", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("b2b_accepted", 32'(cmd_ready), 32'd0);
      col = 4'b0111;
      watch(4'b1110, np, nm, gp);
      chk("b2b_closed", 32'(np), 32'(closed_cycles(2)));
      chk("b2b_row", 32'(nm), 32'(np));

      col = 4'b1101;
      issue(4'd5, 16'd10);
      repeat (BOUNCE ? BOUNCE_CYCLES + 2 : 2) tick();
      chk("pre_reset_row", 32'(row), 32'b1101);
      reset = 1'b0;
      #1;
      chk("async_rst_row", 32'(row), 32'hF);
      chk("async_rst_pressed", 32'(pressed), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      chk("in_rst_done", 32'(done), 32'd0);
      reset = 1'b1;
      chk("rst_release_ready", 32'(cmd_ready), 32'd1);
      repeat (20) tick();

`ifdef KEYPAD_EMU_BOUNCE_EN
      exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      issue(4'd1, 16'd3);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk($sformatf("bounce_seq_%0d", i), 32'(pressed), 32'(exp_seq[i]));
      end
      repeat (GAP_CYCLES + 2) tick();
`else
      exp_seq = '{default: 1'b0};
`endif

      for (int i = 0; i < 500; i++) begin
         if (i % 50 == 0) col = 4'($urandom);
         else if ($urandom_range(0, 3) == 0) col = 4'($urandom);
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_key   = 4'($urandom);
         cmd_hold  = HOLD_W'($urandom_range(0, 6));
         tick();
      end
      cmd_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 SHALL have parameter HOLD_W, default 16: width of the hold-duration field.
REQ-002 SHALL have parameter GAP_CYCLES, default 8: number of release cycles enforced after every press.
REQ-003 SHALL have parameter BOUNCE_CYCLES, default 6: bounce length on press and on release (bounce build only).
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid, input, 1: press command valid.
REQ-007 SHALL have port cmd_ready, output, 1: emulator can accept a command.
REQ-008 SHALL have port cmd_key, input, 4: key index 0-15; row = cmd_key[3:2], column = cmd_key[1:0].
REQ-009 SHALL have port cmd_hold, input, HOLD_W: number of cycles the contact stays closed.
REQ-010 SHALL have port col, input, 4: active-low column drive from the scanner.
REQ-011 SHALL have port row, output, 4: active-low row sense returned to the scanner.
REQ-012 SHALL have port pressed, output, 1: contact currently closed.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when a command completes.

Function
REQ-014 SHALL accept a command on a rising clk edge where cmd_valid and cmd_ready are both high, and SHALL capture cmd_key and cmd_hold on that edge.
REQ-015 SHALL drive cmd_ready high only in state IDLE; cmd_valid while cmd_ready is low SHALL be ignored.
REQ-016 SHALL use states IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT and GAP.
REQ-017 SHALL follow transitions IDLE->BOUNCE_IN (accept) -> HOLD -> BOUNCE_OUT -> GAP -> IDLE.
REQ-018 SHALL keep HOLD for exactly max(cmd_hold,1) cycles, with the contact closed throughout.
REQ-019 SHALL keep GAP for exactly GAP_CYCLES cycles, with the contact open throughout.
REQ-020 SHALL close the contact in HOLD only; it is open in IDLE and GAP.
REQ-021 SHALL register row: row[r] at cycle n+1 = 0 iff the contact is closed at cycle n, r equals the captured row, and col[captured column] = 0 at cycle n; all other row bits SHALL be 1.
REQ-022 SHALL, when several col bits are low together, pull the captured row low if the captured column is among them.
REQ-023 SHALL drive pressed equal to the contact state, registered and aligned with row.
REQ-024 SHALL assert done for exactly one cycle, in the first IDLE cycle after GAP; cmd_ready is also high in that cycle.
REQ-025 SHALL allow back-to-back commands: a command accepted on the done cycle starts immediately.

Reset
REQ-026 SHALL, while reset is low, force state IDLE, row=4'b1111, pressed=0, done=0 and clear all counters, asynchronously.
REQ-027 SHALL, on reset mid-press, release the contact immediately and discard the command without asserting done.
REQ-028 SHALL drive cmd_ready high in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL support macro KEYPAD_EMU_BOUNCE_EN.
REQ-030 SHALL, with KEYPAD_EMU_BOUNCE_EN defined, stay BOUNCE_CYCLES cycles each in BOUNCE_IN and BOUNCE_OUT, with the contact closed on even and open on odd cycle counts (count starts at 0).
REQ-031 SHALL, without KEYPAD_EMU_BOUNCE_EN, compile out the bounce states and counter so transitions are IDLE->HOLD and HOLD->GAP.

Structure
REQ-032 SHALL place the state enum typedef and the key-to-row/column split constants in shared package keypad_pkg.
REQ-033 SHALL implement all durations with one loadable down-counter sub-module, keypad_emu_cnt (load, value, zero flag).

Verification
REQ-034 SHALL verify, without bounce: cmd_key=6, cmd_hold=4, col=4'b1011 constant -> row=4'b1101 for exactly 4 cycles, then 4'b1111; done pulses GAP_CYCLES=8 cycles later.
REQ-035 SHALL verify: cmd_key=6 held, col=4'b0111 -> row stays 4'b1111 while pressed=1.
REQ-036 SHALL verify: col=4'b0000 during the press of cmd_key=15 -> row=4'b0111.
REQ-037 SHALL verify: cmd_hold=0 -> exactly 1 closed cycle; a second command presented on the done cycle is accepted on that cycle.
REQ-038 SHALL verify: reset pulled low during HOLD -> row=4'b1111 immediately, no done, cmd_ready=1 after release.
REQ-039 SHALL verify, with KEYPAD_EMU_BOUNCE_EN, BOUNCE_CYCLES=6 and cmd_hold=3: pressed sequence 1,0,1,0,1,0, 1,1,1, 1,0,1,0,1,0, then 0.
